// File: rtl/conv_layer_input_ctrl_pkg.sv
// Shared conv-layer encodings: FSM states, controller commands, ack codes
// and the pixel data width used by the input cache and this controller.
package conv_layer_input_ctrl_pkg;

    localparam int DATA_WIDTH = 8;

    // Value driven on read_index whenever no pixel fetch is in progress.
    localparam logic [4:0] READ_IDX_NONE = 5'd31;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_PRELOAD = 3'd1,
        ST_ROW_0   = 3'd2,
        ST_ROW_1   = 3'd3,
        ST_ROW_2   = 3'd4,
        ST_BIAS    = 3'd5,
        ST_LOAD    = 3'd6,
        ST_IDLE    = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        CMD_IDLE          = 2'd0,
        CMD_PRELOAD_START = 2'd1,
        CMD_SHIFT_START   = 2'd2,
        CMD_LOAD_START    = 2'd3
    } cmd_t;

    typedef enum logic [1:0] {
        ACK_IDLE        = 2'd0,
        ACK_PRELOAD_FIN = 2'd1,
        ACK_SHIFT_FIN   = 2'd2,
        ACK_LOAD_FIN    = 2'd3
    } ack_t;

endpackage

// File: rtl/conv_layer_input_ctrl.sv
// Input line-cache sequencer: turns preload/shift/load commands into cache
// state, ROM read addresses and one-cycle completion acks.
module conv_layer_input_ctrl
    import conv_layer_input_ctrl_pkg::*;
#(
    parameter int KERNEL_SIZE = 3,
    parameter int IMAGE_SIZE  = 8,
    parameter int ARRAY_SIZE  = 6,
    parameter int ADDR_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            cmd,
    output logic [1:0]            ack,
    output logic [2:0]            current_state,
    output logic [4:0]            read_index,
    output logic [1:0]            preload_cycle,
    output logic [1:0]            array_idx,
    output logic [1:0]            col_idx,
    output logic                  rom_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  image_done
);

    localparam int ROW_W = $clog2(IMAGE_SIZE + 1);

    localparam logic [4:0]       LAST_IDX     = 5'(IMAGE_SIZE - 1);
    localparam logic [4:0]       SHIFT_IDX    = 5'(IMAGE_SIZE);
    localparam logic [1:0]       LAST_COL     = 2'(KERNEL_SIZE - 1);
    localparam logic [1:0]       LAST_PRELOAD = 2'(KERNEL_SIZE - 1);
    localparam logic [ROW_W-1:0] ROW_DONE     = ROW_W'(IMAGE_SIZE);

    // The PE array width is fixed by the image and kernel geometry.
    if (ARRAY_SIZE != IMAGE_SIZE - KERNEL_SIZE + 1) begin : g_bad_array_size
        $error("ARRAY_SIZE must equal IMAGE_SIZE-KERNEL_SIZE+1");
    end

    state_t           state, state_n;
    logic [4:0]       read_index_n;
    logic [1:0]       preload_cycle_n, array_idx_n, col_idx_n;
    logic             rom_en_n, image_done_n;
    ack_t             ack_q, ack_n;
    logic [ROW_W-1:0] row_ptr, row_ptr_n;

    assign current_state = state;
    assign ack           = ack_q;
    assign rom_addr      = ADDR_WIDTH'(row_ptr) * ADDR_WIDTH'(IMAGE_SIZE)
                         + ADDR_WIDTH'(read_index);

    // State and output registers; reset returns to INIT at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_INIT;
            read_index    <= READ_IDX_NONE;
            preload_cycle <= '0;
            array_idx     <= '0;
            col_idx       <= '0;
            rom_en        <= 1'b0;
            ack_q         <= ACK_IDLE;
            row_ptr       <= '0;
            image_done    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register sees pre-edge values of the others.
            state         <= state_n;
            read_index    <= read_index_n;
            preload_cycle <= preload_cycle_n;
            array_idx     <= array_idx_n;
            col_idx       <= col_idx_n;
            rom_en        <= rom_en_n;
            ack_q         <= ack_n;
            row_ptr       <= row_ptr_n;
            image_done    <= image_done_n;
        end
    end

    // Next-state and next-output logic for every command sequence.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latches).
        state_n         = state;
        read_index_n    = READ_IDX_NONE;
        preload_cycle_n = preload_cycle;
        array_idx_n     = '0;
        col_idx_n       = '0;
        rom_en_n        = 1'b0;
        ack_n           = ACK_IDLE;
        row_ptr_n       = row_ptr;

        unique case (state)
            ST_INIT: begin
                state_n         = ST_IDLE;
                preload_cycle_n = '0;
            end
            ST_IDLE: begin
                unique case (cmd)
                    CMD_PRELOAD_START: begin
                        state_n         = ST_PRELOAD;
                        read_index_n    = '0;
                        rom_en_n        = 1'b1;
                        row_ptr_n       = '0;
                        preload_cycle_n = '0;
                    end
                    CMD_SHIFT_START: state_n = ST_ROW_0;
                    CMD_LOAD_START: begin
                        if (image_done) begin
                            ack_n = ACK_LOAD_FIN;
                        end else begin
                            state_n      = ST_LOAD;
                            read_index_n = '0;
                            rom_en_n     = 1'b1;
                        end
                    end
                    default: state_n = ST_IDLE;
                endcase
            end
            ST_PRELOAD: begin
                if (read_index == SHIFT_IDX) begin
                    // Shift cycle: the cache moves rows, the next row starts.
                    read_index_n    = '0;
                    rom_en_n        = 1'b1;
                    row_ptr_n       = row_ptr + 1'b1;
                    preload_cycle_n = preload_cycle + 2'd1;
                end else if (preload_cycle == LAST_PRELOAD && read_index == LAST_IDX) begin
                    // Last row stops before its shift index.
                    state_n   = ST_IDLE;
                    ack_n     = ACK_PRELOAD_FIN;
                    row_ptr_n = row_ptr + 1'b1;
                end else begin
                    read_index_n = read_index + 5'd1;
                    rom_en_n     = (read_index != LAST_IDX);
                end
            end
            ST_ROW_0, ST_ROW_1, ST_ROW_2: begin
                if (col_idx == LAST_COL) begin
                    unique case (state)
                        ST_ROW_0: begin state_n = ST_ROW_1; array_idx_n = 2'd1; end
                        ST_ROW_1: begin state_n = ST_ROW_2; array_idx_n = 2'd2; end
                        default:  state_n = ST_BIAS;
                    endcase
                end else begin
                    col_idx_n   = col_idx + 2'd1;
                    array_idx_n = array_idx;
                end
            end
            ST_BIAS: begin
                state_n = ST_IDLE;
                ack_n   = ACK_SHIFT_FIN;
            end
            ST_LOAD: begin
                if (read_index == LAST_IDX) begin
                    state_n   = ST_IDLE;
                    ack_n     = ACK_LOAD_FIN;
                    row_ptr_n = row_ptr + 1'b1;
                end else begin
                    read_index_n = read_index + 5'd1;
                    rom_en_n     = 1'b1;
                end
            end
            default: state_n = ST_INIT;
        endcase

        image_done_n = (row_ptr_n == ROW_DONE);
    end

endmodule

// File: tb/tb_conv_layer_input_ctrl.sv
// Self-checking bench for conv_layer_input_ctrl: directed scenarios followed
// by random command streams, compared cycle by cycle with a trace model.
module tb_conv_layer_input_ctrl;

    localparam int IMG = 8;

    localparam logic [1:0] C_IDLE = 2'd0, C_PRE = 2'd1, C_SHIFT = 2'd2, C_LOAD = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] cmd = 2'd0;
    logic [1:0] ack, preload_cycle, array_idx, col_idx;
    logic [2:0] current_state;
    logic [4:0] read_index;
    logic       rom_en, image_done;
    logic [7:0] rom_addr;

    conv_layer_input_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd           (cmd),
        .ack           (ack),
        .current_state (current_state),
        .read_index    (read_index),
        .preload_cycle (preload_cycle),
        .array_idx     (array_idx),
        .col_idx       (col_idx),
        .rom_en        (rom_en),
        .rom_addr      (rom_addr),
        .image_done    (image_done)
    );

    always #5 clk = ~clk;

    // Expected per-cycle view of the controller.
    typedef struct {
        int st;
        int ri;
        int en;
        int arr;
        int col;
        int pc;
        int rp;
    } exp_t;

    exp_t q[$];
    int   m_row_ptr = 0;
    int   m_pc      = 0;
    int   ack_now   = 0;
    int   ack_after = 0;
    int   n_checks  = 0;
    int   n_errors  = 0;

    function automatic exp_t mk(int st, int ri, int en, int arr, int col, int pc, int rp);
        exp_t e;
        e.st = st; e.ri = ri; e.en = en; e.arr = arr; e.col = col; e.pc = pc; e.rp = rp;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, expv);
        end
    endtask

    task automatic check_outputs(input exp_t e, input int ack_e);
        check("state",         32'(current_state), 32'(e.st));
        check("read_index",    32'(read_index),    32'(e.ri));
        check("rom_en",        32'(rom_en),        32'(e.en));
        check("rom_addr",      32'(rom_addr),      32'((e.rp * IMG + e.ri) % 256));
        check("array_idx",     32'(array_idx),     32'(e.arr));
        check("col_idx",       32'(col_idx),       32'(e.col));
        check("preload_cycle", 32'(preload_cycle), 32'(e.pc));
        check("ack",           32'(ack),           32'(ack_e));
        check("image_done",    32'(image_done),    32'(e.rp == IMG));
    endtask

    // Builds the full expected trace of an accepted command.
    task automatic model_accept(input logic [1:0] c);
        case (c)
            C_PRE: begin
                for (int r = 0; r < 3; r++)
                    for (int i = 0; i <= ((r == 2) ? 7 : 8); i++)
                        q.push_back(mk(1, i, (i != 8) ? 1 : 0, 0, 0, r, r));
                m_row_ptr = 3;
                m_pc      = 2;
                ack_after = 1;
            end
            C_SHIFT: begin
                for (int s = 0; s < 3; s++)
                    for (int k = 0; k < 3; k++)
                        q.push_back(mk(2 + s, 31, 0, s, k, m_pc, m_row_ptr));
                q.push_back(mk(5, 31, 0, 0, 0, m_pc, m_row_ptr));
                ack_after = 2;
            end
            C_LOAD: begin
                if (m_row_ptr == IMG) begin
                    ack_now = 3;
                end else begin
                    for (int i = 0; i < 8; i++)
                        q.push_back(mk(6, i, 1, 0, 0, m_pc, m_row_ptr));
                    m_row_ptr++;
                    ack_after = 3;
                end
            end
            default: ;
        endcase
    endtask

    // One clock: check at the falling edge, then drive the next command.
    task automatic cycle(input logic [1:0] idle_cmd, input logic [1:0] busy_cmd);
        exp_t e;
        @(negedge clk);
        if (q.size() > 0) begin
            e = q.pop_front();
            check_outputs(e, 0);
            if (q.size() == 0) ack_now = ack_after;
            cmd = busy_cmd;
        end else begin
            check_outputs(mk(7, 31, 0, 0, 0, m_pc, m_row_ptr), ack_now);
            ack_now = 0;
            cmd = idle_cmd;
            model_accept(idle_cmd);
        end
    endtask

    task automatic run_cmd(input logic [1:0] c, input logic [1:0] busy_cmd);
        cycle(c, busy_cmd);
        while (q.size() > 0) cycle(C_IDLE, busy_cmd);
    endtask

    // Asynchronous reset pulse, then one INIT cycle before IDLE.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_outputs(mk(0, 31, 0, 0, 0, 0, 0), 0);
        q.delete();
        m_row_ptr = 0; m_pc = 0; ack_now = 0; ack_after = 0;
        cmd = C_IDLE;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_outputs(mk(0, 31, 0, 0, 0, 0, 0), 0);
    endtask

    logic [1:0] pick;

    initial begin
        #3;
        do_reset();

        // Preload with shift held throughout; shift accepted in the ack cycle.
        run_cmd(C_PRE, C_SHIFT);
        run_cmd(C_SHIFT, C_SHIFT);

        // Five loads fill the image, the sixth returns at once.
        for (int k = 0; k < 6; k++) run_cmd(C_LOAD, 2'($urandom_range(0, 3)));
        cycle(C_IDLE, C_IDLE);

        // Reset in the middle of preload row 1, index 4.
        cycle(C_PRE, C_IDLE);
        repeat (14) cycle(C_IDLE, C_IDLE);
        do_reset();
        run_cmd(C_PRE, C_IDLE);
        cycle(C_IDLE, C_IDLE);

        // Random command stream with random commands while busy.
        repeat (1500) begin
            pick = ($urandom_range(0, 9) < 4) ? C_IDLE : 2'($urandom_range(1, 3));
            cycle(pick, 2'($urandom_range(0, 3)));
        end
        while (q.size() > 0) cycle(C_IDLE, C_IDLE);
        cycle(C_IDLE, C_IDLE);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/conv_layer_input_ctrl.md
# conv_layer_input_ctrl

Sequencer for the conv-layer input line cache. It accepts coarse commands from the layer top-level controller (preload, shift, load) and drives the cache's `current_state`, `read_index`, `preload_cycle` and `array_idx` inputs. It also generates input-ROM read addresses and reports completion with one-cycle ack codes. It sits between the layer controller, the input ROM and the three-row input cache that feeds the 6-wide PE array.

## Interface
- `KERNEL_SIZE`, 3: kernel rows/columns; cycles per ROW state.
- `IMAGE_SIZE`, 8: pixels per row and rows per image.
- `ARRAY_SIZE`, 6: PE array width (informational; `IMAGE_SIZE-KERNEL_SIZE+1`).
- `ADDR_WIDTH`, 8: ROM address width.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cmd`  in  2  CMD_IDLE=0, CMD_PRELOAD_START=1, CMD_SHIFT_START=2, CMD_LOAD_START=3.
- `ack`  out  2  ACK_IDLE=0, ACK_PRELOAD_FIN=1, ACK_SHIFT_FIN=2, ACK_LOAD_FIN=3; one-cycle pulse.
- `current_state`  out  3  INIT=0, PRELOAD=1, ROW_0=2, ROW_1=3, ROW_2=4, BIAS=5, LOAD=6, IDLE=7.
- `read_index`  out  5  pixel index within the row being fetched; 0..8; 31 when not fetching.
- `preload_cycle`  out  2  preload row number, 0..2.
- `array_idx`  out  2  cache row selected for the PE array.
- `col_idx`  out  2  kernel column within the current ROW state, 0..KERNEL_SIZE-1.
- `rom_en`  out  1  ROM read strobe.
- `rom_addr`  out  ADDR_WIDTH  `row_ptr*IMAGE_SIZE + read_index`.
- `image_done`  out  1  high when `row_ptr == IMAGE_SIZE`.

## Operation
- Reset values:
  - `current_state` = INIT, `read_index` = 31, all other outputs and `row_ptr` = 0.
  - INIT lasts one cycle and then moves to IDLE. Reset asserted mid-operation returns to INIT immediately.
- `cmd` is sampled only in IDLE. Commands in any other state are ignored (not queued).
- PRELOAD:
  - `row_ptr` clears to 0 on entry.
  - Rows 0 and 1 (`preload_cycle` 0, 1) step `read_index` 0..8. Index 8 is the shift cycle: `rom_en` = 0, then `row_ptr` += 1 and `preload_cycle` += 1.
  - Row 2 steps `read_index` 0..7 only. `read_index` = 8 with `preload_cycle` = 2 must never be driven, because it would trigger an extra shift.
  - After `read_index` 7 of row 2: `row_ptr` = 3, go to IDLE, `ack` = PRELOAD_FIN.
- SHIFT (CMD_SHIFT_START):
  - States run ROW_0, ROW_1, ROW_2, each for KERNEL_SIZE cycles. `col_idx` counts 0..2 in each state.
  - `array_idx` = 0/1/2 in ROW_0/1/2 respectively.
  - BIAS follows for 1 cycle, then IDLE with `ack` = SHIFT_FIN.
  - `rom_en` = 0 throughout.
- LOAD (CMD_LOAD_START):
  - If `image_done` = 1: go straight to IDLE with `ack` = LOAD_FIN. No ROM reads, no LOAD state entered.
  - Otherwise `read_index` steps 0..7 with `rom_en` = 1. The cache performs its row shift at index 0.
  - After index 7: `row_ptr` += 1, go to IDLE, `ack` = LOAD_FIN.
- `read_index` = 31 and `rom_en` = 0 in INIT, IDLE, ROW_*, BIAS. `array_idx` = 0 and `col_idx` = 0 outside ROW states.
- `preload_cycle` holds its last value outside PRELOAD. It clears on PRELOAD entry and on INIT.
- `rom_addr` width rule: the product is truncated to ADDR_WIDTH; the maximum is 63.

## Timing
- All outputs are registered except `rom_addr`, which is combinational from registered `row_ptr`/`read_index`.
- ROM is asynchronous-read: `data_in` must be valid in the same cycle as `rom_addr`/`read_index`.
- Cmd accepted in cycle t: first active state in t+1; `ack` pulses in the first IDLE cycle after completion. A new command is accepted in that same cycle.
- Latencies from command accept to `ack`:
  - preload: 26 active cycles (9+9+8), ack at t+27;
  - shift: 10 active cycles, ack at t+11;
  - load: 8 active cycles, ack at t+9;
  - load when `image_done` = 1: ack at t+1.

## Structure
- Move state, CMD and ACK encodings into the shared conv-layer define header, alongside `DATA_WIDTH`. The cache and this controller both include it.
- Implementation is a single flat module: one FSM plus `read_index`, `col_idx`, `preload_cycle` and `row_ptr` counters. No sub-module.

## Test plan
- Reset, then release: INIT for 1 cycle, then IDLE; `read_index` = 31, `ack` = 0, `rom_en` = 0, `image_done` = 0.
- CMD_PRELOAD_START: `rom_addr` sequence 0..7, (shift), 8..15, (shift), 16..23. Exactly two cycles show `read_index` = 8. Ack PRELOAD_FIN at t+27; `row_ptr` = 3.
- CMD_SHIFT_START: states ROW_0×3, ROW_1×3, ROW_2×3, BIAS×1. `array_idx` 0,1,2 and `col_idx` 0,1,2 per state. Ack SHIFT_FIN at t+11; no `rom_en`.
- Five CMD_LOAD_START after preload: addresses 24..31 through 56..63, each ack at t+9, then `image_done` = 1. A sixth load gives ack LOAD_FIN at t+1 with no `rom_en` and state never LOAD.
- CMD_SHIFT_START held continuously during a preload: ignored until the PRELOAD_FIN cycle, then accepted in that cycle.
- `rst_n` pulsed low at preload row 1, index 4: all outputs at reset values asynchronously. A following preload restarts at `rom_addr` 0.
